// File: rtl/spu_pwl_pkg.sv
// spu_pwl_pkg: shared encodings, default widths and accumulator sizing for the PWL unit
package spu_pwl_pkg;
  typedef enum logic [1:0] {CFG_BP, CFG_COEF, CFG_BIAS, CFG_RSV} cfg_sel_e;
  localparam int DEF_LANES  = 4;
  localparam int DEF_SEGS   = 8;
  localparam int DEF_DIN_W  = 9;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_BIAS_W = 16;
  localparam int DEF_FRAC   = 6;
  localparam int DEF_DOUT_W = 8;
  function automatic int acc_w(input int cw, input int dw, input int bw);
    return ((cw + dw) > bw ? cw + dw : bw) + 1;
  endfunction
endpackage

// File: rtl/spu_pwl_lane.sv
// spu_pwl_lane: one lane of segment search, multiply-add and clamp/shift/round
module spu_pwl_lane import spu_pwl_pkg::*; #(
  parameter int SEGS   = DEF_SEGS,
  parameter int DIN_W  = DEF_DIN_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int BIAS_W = DEF_BIAS_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int DOUT_W = DEF_DOUT_W
) (
  input  logic                           core_clk,
  input  logic                           rst_n,
  input  logic                           s1_ld,
  input  logic                           s2_ld,
  input  logic                           s3_ld,
  input  logic [DIN_W-1:0]               x,
  input  logic [SEGS-2:0][DIN_W-1:0]     bp,
  input  logic [SEGS-1:0][COEF_W-1:0]    coef,
  input  logic [SEGS-1:0][BIAS_W-1:0]    bias,
  input  logic [3:0]                     shift,
  output logic [DOUT_W-1:0]              dout
);
  localparam int IW  = $clog2(SEGS);
  localparam int AW  = acc_w(COEF_W, DIN_W, BIAS_W);
  localparam int SW  = AW + 15;
  localparam int IPW = SW - FRAC;
  localparam logic [IPW:0] DMAX = (IPW+1)'((2 ** DOUT_W) - 1);
  logic [IW-1:0]           idx, idx_r;
  logic signed [DIN_W-1:0] x_r;
  logic signed [AW-1:0]    acc, acc_r;
  logic [SW-1:0]           sh;
  logic [IPW:0]            ip;
  logic                    rnd;
  // first breakpoint the input falls below wins, so scan from the top down
  always_comb begin
    idx = IW'(SEGS - 1);
    for (int i = SEGS - 2; i >= 0; i--)
      idx = ($signed(x) < $signed(bp[i])) ? IW'(i) : idx;
  end
  assign acc = AW'($signed(coef[idx_r])) * AW'(x_r) + AW'($signed(bias[idx_r]));
  assign sh  = acc_r[AW-1] ? '0 : {15'd0, acc_r} << shift;
  assign rnd = sh[FRAC-1] & (sh[FRAC] | (|sh[FRAC-2:0]));
  assign ip  = {1'b0, sh[SW-1:FRAC]} + (IPW+1)'(rnd);
  // S1 index/x, S2 accumulator, S3 saturated result
  always_ff @(posedge core_clk or negedge rst_n)
    if (!rst_n) begin
      idx_r <= '0;
      x_r   <= '0;
      acc_r <= '0;
      dout  <= '0;
    end else begin
      if (s1_ld) idx_r <= idx;
      if (s1_ld) x_r <= $signed(x);
      if (s2_ld) acc_r <= acc;
      if (s3_ld) dout <= (ip >= DMAX) ? {DOUT_W{1'b1}} : ip[DOUT_W-1:0];
    end
endmodule

// File: rtl/spu_pwl_vec.sv
// spu_pwl_vec: multi-lane elastic 3-stage piecewise-linear function unit with shared tables
module spu_pwl_vec import spu_pwl_pkg::*; #(
  parameter int LANES  = DEF_LANES,
  parameter int SEGS   = DEF_SEGS,
  parameter int DIN_W  = DEF_DIN_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int BIAS_W = DEF_BIAS_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int DOUT_W = DEF_DOUT_W
) (
  input  logic                      core_clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_sel,
  input  logic [$clog2(SEGS)-1:0]   cfg_addr,
  input  logic [BIAS_W-1:0]         cfg_wdata,
  input  logic [3:0]                cfg_shift,
  output logic                      cfg_err,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DIN_W-1:0]    in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DOUT_W-1:0]   out_data,
  output logic                      busy
);
  localparam int IW = $clog2(SEGS);
  logic [SEGS-2:0][DIN_W-1:0]  bp_t;
  logic [SEGS-1:0][COEF_W-1:0] coef_t;
  logic [SEGS-1:0][BIAS_W-1:0] bias_t;
  logic s1_valid, s2_valid, s3_valid;
  logic s1_adv, s2_adv, s2_room, s3_room, accept, cfg_ok, cfg_live;
  assign s3_room   = !s3_valid || out_ready;
  assign s2_adv    = s2_valid && s3_room;
  assign s2_room   = !s2_valid || s2_adv;
  assign s1_adv    = s1_valid && s2_room;
  assign in_ready  = !s1_valid || s1_adv;
  assign accept    = in_valid && in_ready;
  assign busy      = s1_valid || s2_valid || s3_valid;
  assign out_valid = s3_valid;
  assign cfg_live  = cfg_we && (cfg_sel != CFG_RSV);
  assign cfg_ok    = cfg_live && !busy && !in_valid;
  // stage valids: a stage takes its predecessor whenever it has room
  always_ff @(posedge core_clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_room) s2_valid <= s1_valid;
      if (s3_room) s3_valid <= s2_valid;
    end
  // table writes are only safe with an empty pipe and no beat on the input
  always_ff @(posedge core_clk or negedge rst_n)
    if (!rst_n) begin
      bp_t    <= '0;
      coef_t  <= '0;
      bias_t  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_live && !cfg_ok;
      if (cfg_ok && cfg_sel == CFG_BP && cfg_addr != IW'(SEGS - 1)) bp_t[cfg_addr] <= cfg_wdata[DIN_W-1:0];
      if (cfg_ok && cfg_sel == CFG_COEF) coef_t[cfg_addr] <= cfg_wdata[COEF_W-1:0];
      if (cfg_ok && cfg_sel == CFG_BIAS) bias_t[cfg_addr] <= cfg_wdata;
    end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    spu_pwl_lane #(
      .SEGS(SEGS), .DIN_W(DIN_W), .COEF_W(COEF_W),
      .BIAS_W(BIAS_W), .FRAC(FRAC), .DOUT_W(DOUT_W)
    ) u_lane (
      .core_clk(core_clk),
      .rst_n(rst_n),
      .s1_ld(accept),
      .s2_ld(s1_adv),
      .s3_ld(s2_adv),
      .x(in_data[l*DIN_W +: DIN_W]),
      .bp(bp_t),
      .coef(coef_t),
      .bias(bias_t),
      .shift(cfg_shift),
      .dout(out_data[l*DOUT_W +: DOUT_W])
    );
  end
endmodule

// File: tb/tb_spu_pwl_vec.sv
// tb_spu_pwl_vec: directed vector bench for the PWL unit
module tb_spu_pwl_vec;
  logic        core_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic [3:0]  cfg_shift = 4'd0;
  logic        cfg_err;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [35:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        busy;
  int n_vec = 0;
  int n_err = 0;
  int bp_m[7];
  int coef_m[8];
  int bias_m[8];
  logic [35:0] beats[20];
  logic [31:0] expv[20];
  logic [31:0] d;
  int sent, got, acc_cyc, ov_cyc;

  spu_pwl_vec dut (
    .core_clk(core_clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_shift(cfg_shift), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_pwl(input int x);
    int s = 7;
    longint acc, ip, rem;
    for (int i = 6; i >= 0; i--) if (x < bp_m[i]) s = i;
    acc = longint'(coef_m[s]) * x + bias_m[s];
    if (acc < 0) acc = 0;
    acc = acc << cfg_shift;
    ip = acc / 64;
    rem = acc % 64;
    if (rem > 32 || (rem == 32 && ip % 2 == 1)) ip++;
    if (ip > 255) ip = 255;
    return 8'(ip);
  endfunction

  function automatic logic [31:0] ref_beat(input logic [35:0] b);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[l*8 +: 8] = ref_pwl(int'($signed(b[l*9 +: 9])));
    return r;
  endfunction

  function automatic logic [35:0] pack(input int x0, input int x1, input int x2, input int x3);
    return {9'(x3), 9'(x2), 9'(x1), 9'(x0)};
  endfunction

  task automatic cfg_wr(input int sel, input int addr, input int data);
    @(posedge core_clk); #1;
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_addr = 3'(addr); cfg_wdata = 16'(data);
    @(posedge core_clk); #1;
    cfg_we = 1'b0;
    if (sel == 0) bp_m[addr] = data;
    if (sel == 1) coef_m[addr] = data;
    if (sel == 2) bias_m[addr] = data;
  endtask

  task automatic eval(input logic [35:0] b, output logic [31:0] r);
    @(posedge core_clk); #1;
    in_valid = 1'b1; in_data = b;
    @(posedge core_clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) @(negedge core_clk);
    if (!out_valid) chk("eval_timeout", 32'd0, 32'd1);
    r = out_data;
    @(posedge core_clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin coef_m[i] = 0; bias_m[i] = 0; end
    for (int i = 0; i < 7; i++) bp_m[i] = 0;
    repeat (3) @(negedge core_clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    @(negedge core_clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    for (int i = 0; i < 7; i++) cfg_wr(0, i, -192 + 32 * i);
    // segment search
    for (int i = 0; i < 8; i++) cfg_wr(2, i, i << 6);
    eval(pack(-200, -192, -32, 10), d);
    chk("seg_x-200", 32'(d[7:0]), 32'd0);
    chk("seg_x-192", 32'(d[15:8]), 32'd1);
    chk("seg_x-32", 32'(d[23:16]), 32'd6);
    chk("seg_x10", 32'(d[31:24]), 32'd7);
    // rounding
    cfg_wr(2, 7, 96);  eval(pack(10, 10, 10, 10), d); chk("rnd_96", d, {4{8'd2}});
    cfg_wr(2, 7, 160); eval(pack(10, 10, 10, 10), d); chk("rnd_160_even", d, {4{8'd2}});
    cfg_wr(2, 7, 161); eval(pack(10, 10, 10, 10), d); chk("rnd_161", d, {4{8'd3}});
    cfg_wr(2, 7, 84);  eval(pack(10, 10, 10, 10), d); chk("rnd_84", d, {4{8'd1}});
    // clamp and saturate
    cfg_shift = 4'd4;
    cfg_wr(2, 7, -100);  eval(pack(10, 10, 10, 10), d); chk("clamp_neg", d, {4{8'd0}});
    cfg_wr(2, 7, 32767); eval(pack(10, 10, 10, 10), d); chk("sat_max", d, {4{8'd255}});
    cfg_shift = 4'd0;
    cfg_wr(1, 7, 127); cfg_wr(2, 7, 0);
    eval(pack(10, 10, 10, 10), d); chk("mac_1270", d, {4{8'd20}});
    // backpressure with a model-driven scoreboard
    cfg_shift = 4'd1;
    for (int i = 0; i < 8; i++) begin cfg_wr(1, i, 16 * i - 50); cfg_wr(2, i, 400 * i - 300); end
    for (int k = 0; k < 20; k++) begin
      beats[k] = {$urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511)};
      expv[k] = ref_beat(beats[k]);
    end
    sent = 0; got = 0; acc_cyc = -1; ov_cyc = -1;
    for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
      @(posedge core_clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (sent < 20);
      in_data = beats[sent < 20 ? sent : 19];
      @(negedge core_clk);
      if (out_valid && ov_cyc < 0) ov_cyc = cyc;
      if (out_valid && got >= 20) chk("bp_extra", 32'd1, 32'd0);
      if (out_valid && got < 20) chk(out_ready ? "bp_data" : "bp_stall", out_data, expv[got]);
      if (out_valid && out_ready) got++;
      if (in_valid && in_ready) begin
        if (sent == 0) acc_cyc = cyc;
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 32'(got), 32'd20);
    chk("bp_latency", 32'(ov_cyc - acc_cyc), 32'd3);
    repeat (5) @(negedge core_clk);
    chk("bp_no_dup", 32'(out_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    // config guard
    cfg_shift = 4'd0;
    @(posedge core_clk); #1;
    in_valid = 1'b1; in_data = pack(10, 10, 10, 10);
    @(posedge core_clk); #1;
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_addr = 3'd7; cfg_wdata = 16'd5;
    @(negedge core_clk);
    chk("guard_err_early", 32'(cfg_err), 32'd0);
    @(posedge core_clk); #1;
    cfg_we = 1'b0;
    @(negedge core_clk);
    chk("guard_err_pulse", 32'(cfg_err), 32'd1);
    @(negedge core_clk);
    chk("guard_err_clear", 32'(cfg_err), 32'd0);
    repeat (4) @(posedge core_clk);
    eval(pack(10, 10, 10, 10), d);
    chk("guard_keep", d, {4{8'd49}});
    cfg_wr(1, 7, 5);
    @(negedge core_clk);
    chk("guard_idle_err", 32'(cfg_err), 32'd0);
    eval(pack(10, 10, 10, 10), d);
    chk("guard_new", d, {4{8'd40}});
    chk("guard_model", d, ref_beat(pack(10, 10, 10, 10)));
    // reset mid-stream
    @(posedge core_clk); #1;
    in_valid = 1'b1; in_data = pack(10, 20, 30, 40);
    repeat (3) @(posedge core_clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge core_clk);
    rst_n = 1'b1;
    eval(pack(10, 10, 10, 10), d);
    chk("post_rst_zero", d, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spu_pwl_vec.md
# spu_pwl_vec

Multi-lane, pipelined piecewise-linear (PWL) function unit for the softmax processing unit (SPU). It evaluates `y = clamp(round((coeff[s]*x + bias[s]) << shift >> FRAC))` on `LANES` signed inputs per beat, where `s` is the segment found by comparing `x` against a programmable breakpoint table. It is the parametrised successor of the single-lane EXPU PWL stage:
- segment count, widths and lane count are parameters;
- tables are loaded through a config write port;
- data moves on a valid/ready elastic 3-stage pipeline instead of being gated by `sm_state`.

## Interface
- `LANES`, 4, lanes evaluated per beat
- `SEGS`, 8, segments; `SEGS-1` breakpoints; power of two, ≥2
- `DIN_W`, 9, signed input width
- `COEF_W`, 8, signed coefficient width
- `BIAS_W`, 16, signed bias width
- `FRAC`, 6, fractional bits of `coeff*x+bias`
- `DOUT_W`, 8, unsigned output width
- `core_clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  table write strobe
- `cfg_sel`  in  2  0 = breakpoint, 1 = coeff, 2 = bias, 3 = reserved (ignored)
- `cfg_addr`  in  log2(SEGS)  table entry
- `cfg_wdata`  in  BIAS_W  write data, low bits used for narrower tables
- `cfg_shift`  in  4  output scale left shift, sampled per beat at S3
- `cfg_err`  out  1  one-cycle pulse: write rejected
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when high with `in_valid`
- `in_data`  in  LANES*DIN_W  lane i at `[i*DIN_W +: DIN_W]`
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  LANES*DOUT_W  lane i at `[i*DOUT_W +: DOUT_W]`
- `busy`  out  1  any pipeline stage holds a valid beat

## Operation
**Segment search (S1)**
- `s` is the smallest i with `x < bp[i]`; otherwise `s = SEGS-1`.
- This rule is deterministic even for non-monotonic tables.
- Compares are signed and per lane.

**Multiply-add (S2)**
- `acc = coeff[s]*x + bias[s]`, full precision.
- `ACC_W = max(COEF_W+DIN_W, BIAS_W) + 1`, so no wrap.

**Output scaling (S3), in order**
1. If `acc < 0`, use 0.
2. Left-shift by `cfg_shift` into `ACC_W+15` bits.
3. Round half-to-even at bit `FRAC-1`:
   - round up if `b[FRAC-1] && (b[FRAC] || |b[FRAC-2:0])`.
4. Saturate to `2^DOUT_W-1` if the integer part, or integer part plus round, reaches that value.

**Config writes**
- A write is accepted only when `busy==0` and `in_valid==0`.
- Otherwise the write is dropped and `cfg_err` pulses the next cycle.
- `cfg_sel==3` is ignored, with no error.
- An accepted write is visible to the first beat accepted the following cycle.

**Reset**
- `rst_n` low at any time, including mid-stream, clears all stage valids and all tables to 0.
- `out_data`, `out_valid`, `cfg_err` and `busy` reset to 0.
- `in_ready` resets to 1 once `rst_n` is high.

## Timing
**Pipeline**
- Three registered stages: S1 (index + x), S2 (acc), S3 (`out_data`/`out_valid`).
- Latency: 3 cycles from the accept edge to `out_valid` when not stalled.
- Throughput: 1 beat per cycle.

**Stage advance and backpressure**
- Stage k loads when it is empty or its content moves forward the same cycle.
- S3 moves forward when `out_ready`.
- `in_ready = !s1_valid || s1_adv`, a combinational chain back from `out_ready`.
- Bubble-free: `out_ready` low for N cycles with a full pipe then high resumes with no lost or duplicated beat.
- `out_data` holds stable while `out_valid && !out_ready`.

**Other timing**
- `busy` is the OR of registered stage valids.
- `cfg_shift` changes mid-stream apply to beats that load into S3 that cycle or later.

## Structure
**Package `spu_pwl_pkg`:**
- `cfg_sel` encodings `CFG_BP`, `CFG_COEF`, `CFG_BIAS`.
- Default widths.
- `ACC_W` function.

**Sub-module `spu_pwl_lane`:**
- One lane of S1–S3 datapath: compare, mux, MAC, clamp/shift/round.
- Instantiated `LANES` times.
- Tables and valid/ready control are shared in the top.

## Test plan
Table setup for all scenarios: `bp[i] = -192+32*i` (i=0..6).

1. Segment search: coeff all 0, `bias[s] = s<<6`, shift 0; x = -200, -192, -32, 10 → out 0, 1, 6, 7.
2. Rounding, coeff 0, shift 0, x = 10 (segment 7):
   - `bias[7]` = 96 → out 2;
   - `bias[7]` = 160 → out 2 (tie to even);
   - `bias[7]` = 161 → out 3;
   - `bias[7]` = 84 → out 1.
3. Clamp and saturate, shift 4, x = 10:
   - `bias[7]` = -100, coeff 0 → out 0;
   - `bias[7]` = 32767 → out 255;
   - `coeff[7]` = 127, `bias[7]` = 0, shift 0 → 1270/64 = 19.84 → out 20.
4. Backpressure: 20 back-to-back beats with random `out_ready` (50%) → 20 outputs, in order, values match model, `out_data` stable while stalled, first output 3 cycles after first accept.
5. Config guard: `cfg_we` while `busy` → table unchanged, `cfg_err` pulse 1 cycle later; same write when idle → next beat uses the new value.
6. Reset mid-stream with 3 beats in flight → `out_valid` 0, `busy` 0, tables 0; post-reset beat x = 10 → out 0.
